// File: rtl/nn_neuron_pkg.sv
// Shared types and arithmetic helpers for the neuron MAC blocks.
package nn_neuron_pkg;

  typedef enum logic [2:0] {IDLE, ACC, BIAS, ACT, DONE} state_t;

  // Wide enough to hold a 2*DW accumulator plus an 8-lane adder tree for DW <= 32.
  localparam int SAT_W = 72;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  function automatic int nbeats(input int nw, input int lanes);
    return (nw + lanes - 1) / lanes;
  endfunction

  // Signed add of two sign-extended operands, clamped to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                r;
    one   = 1;
    sum   = a + b;
    hi    = (one <<< (w - 1)) - one;
    lo    = ~hi;
    r.sat = (sum > hi) || (sum < lo);
    if (sum > hi)      r.val = hi;
    else if (sum < lo) r.val = lo;
    else               r.val = sum;
    return r;
  endfunction

endpackage

// File: rtl/neuron_weight_bank.sv
// Weight storage: serial write port, LANES-wide registered read indexed by beat.
module neuron_weight_bank
  import nn_neuron_pkg::*;
#(
  parameter int DW     = 16,
  parameter int LANES  = 2,
  parameter int NBEATS = 15,
  parameter int WPW    = 5,
  parameter int BCW    = 4
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [WPW-1:0]      wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic [BCW-1:0]      rd_beat,
  output logic [LANES*DW-1:0] rd_data
);

  localparam int DEPTH = NBEATS * LANES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [2**AW];

  // rd_beat is the beat about to be presented, so rd_data lines up with the accept edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[AW'(wr_addr)] <= wr_data;
    for (int k = 0; k < LANES; k++) begin
      rd_data[k*DW +: DW] <= mem[AW'(int'(rd_beat) * LANES + k)];
    end
  end

endmodule

// File: rtl/neuron_mac_multilane.sv
// Multi-lane neuron MAC: runtime weights/bias, saturating accumulate, ReLU/linear output.
// Optional sticky saturation flag built only when NEURON_SAT_FLAG_EN is defined.
//
// state | meaning
// IDLE  | waiting for first beat; config writes allowed
// ACC   | accepting beats, summing lane products into acc
// BIAS  | acc += scaled bias
// ACT   | activation, out registered
// DONE  | out_valid pulse; acc and beat counter cleared
module neuron_mac_multilane
  import nn_neuron_pkg::*;
#(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = 16,
  parameter int W_INT      = 1,
  parameter int LANES      = 2,
  parameter int ACT_RELU   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  input  logic                        weight_valid,
  input  logic [31:0]                 weight_value,
  input  logic                        bias_valid,
  input  logic [31:0]                 bias_value,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0]       out,
  output logic                        out_valid,
  output logic                        sat_flag
);

  localparam int DW     = DATA_WIDTH;
  localparam int PW     = 2 * DW;
  localparam int TW     = PW + $clog2(LANES);
  localparam int NBEATS = nbeats(NUM_WEIGHT, LANES);
  localparam int WPW    = $clog2(NUM_WEIGHT + 1);
  localparam int BCW    = $clog2(NBEATS + 1);

  state_t                  state, state_nxt;
  logic [WPW-1:0]          wptr;
  logic                    w_loaded;
  logic [DW-1:0]           bias_reg;
  logic [BCW-1:0]          beat_cnt, beat_nxt;
  logic signed [PW-1:0]    acc;
  logic signed [PW-1:0]    prod [LANES];
  logic                    prod_vld, prod_last;
  logic [LANES*DW-1:0]     w_beat;
  logic signed [TW-1:0]    lane_sum;
  logic signed [PW-1:0]    bias_ext;
  sat_res_t                sum_acc, sum_bias;
  logic [W_INT:0]          top_bits;
  logic [DW-1:0]           act_y;
  logic                    cfg_hit, accept, wr_ok, bias_ok;

  assign cfg_hit  = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign wr_ok    = weight_valid && cfg_hit && (state == IDLE) && (wptr < WPW'(NUM_WEIGHT));
  assign bias_ok  = bias_valid && cfg_hit && (state == IDLE);
  assign in_ready = w_loaded && ((state == IDLE) || (state == ACC)) && (beat_cnt < BCW'(NBEATS));
  assign accept   = in_valid && in_ready;
  assign beat_nxt = (state == DONE) ? '0 : beat_cnt + BCW'(accept);

  neuron_weight_bank #(
    .DW(DW), .LANES(LANES), .NBEATS(NBEATS), .WPW(WPW), .BCW(BCW)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wptr),
    .wr_data (weight_value[DW-1:0]),
    .rd_beat (beat_nxt),
    .rd_data (w_beat)
  );

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (accept) begin
        if ((int'(beat_cnt) * LANES + k) < NUM_WEIGHT)
          prod[k] <= $signed(w_beat[k*DW +: DW]) * $signed(in_data[k*DW +: DW]);
        else
          prod[k] <= '0;
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + TW'(prod[k]);
    bias_ext = PW'($signed(bias_reg)) <<< (DW - W_INT);
    sum_acc  = sat_add(SAT_W'(acc), SAT_W'(lane_sum), PW);
    sum_bias = sat_add(SAT_W'(acc), SAT_W'(bias_ext), PW);
  end

  // Output window is acc[PW-1-W_INT -: DW]; saturate when the guard bits disagree.
  always_comb begin
    top_bits = acc[PW-1 -: W_INT+1];
    if (!((&top_bits) || !(|top_bits)))
      act_y = acc[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      act_y = acc[PW-1-W_INT -: DW];
    if ((ACT_RELU != 0) && acc[PW-1]) act_y = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC;
      ACC:     if (prod_last) state_nxt = BIAS;
      BIAS:    state_nxt = ACT;
      ACT:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      w_loaded  <= 1'b0;
      bias_reg  <= '0;
      beat_cnt  <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      out_valid <= (state_nxt == DONE);
      w_loaded  <= w_loaded || (wptr == WPW'(NUM_WEIGHT));
      prod_vld  <= accept;
      prod_last <= accept && (beat_cnt == BCW'(NBEATS - 1));
      if (wr_ok)   wptr     <= wptr + 1'b1;
      if (bias_ok) bias_reg <= bias_value[DW-1:0];
      case (state)
        ACC:     if (prod_vld) acc <= sum_acc.val[PW-1:0];
        BIAS:    acc <= sum_bias.val[PW-1:0];
        ACT:     out <= act_y;
        DONE:    acc <= '0;
        default: ;
      endcase
    end
  end

`ifdef NEURON_SAT_FLAG_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (rst)
      sat_q <= 1'b0;
    else if (((state == ACC) && prod_vld && sum_acc.sat) || ((state == BIAS) && sum_bias.sat))
      sat_q <= 1'b1;
    else if ((state == IDLE) && accept)
      sat_q <= 1'b0;
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_mac_multilane.sv
// Scoreboard bench: four neuron instances (ReLU, linear, single-lane, masked tail) on one config bus.
module tb_neuron_mac_multilane;

  localparam int NW_OF   [4] = '{4, 4, 4, 3};
  localparam int LANES_OF[4] = '{2, 2, 1, 2};
  localparam int RELU_OF [4] = '{1, 0, 1, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] config_layer_num, config_neuron_num, weight_value, bias_value;
  logic        weight_valid, bias_valid, in_valid;
  logic [31:0] in_data;
  int          sel;
  logic        rdy [4];
  logic        ov  [4];
  logic        sat [4];
  logic [15:0] outs[4];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_acc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] wm [4][8];
  logic [15:0] bm [4];
  logic [15:0] xv [8];
  logic [15:0] mon_e;
  bit          exp_sat;

  always #5 clk = ~clk;

  neuron_mac_multilane #(.NEURON_NO(0), .NUM_WEIGHT(4), .LANES(2), .ACT_RELU(1)) u_a (
    .clk(clk), .rst(rst), .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value), .bias_valid(bias_valid),
    .bias_value(bias_value), .in_valid(in_valid && (sel == 0)), .in_ready(rdy[0]),
    .in_data(in_data), .out(outs[0]), .out_valid(ov[0]), .sat_flag(sat[0]));

  neuron_mac_multilane #(.NEURON_NO(1), .NUM_WEIGHT(4), .LANES(2), .ACT_RELU(0)) u_b (
    .clk(clk), .rst(rst), .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value), .bias_valid(bias_valid),
    .bias_value(bias_value), .in_valid(in_valid && (sel == 1)), .in_ready(rdy[1]),
    .in_data(in_data), .out(outs[1]), .out_valid(ov[1]), .sat_flag(sat[1]));

  neuron_mac_multilane #(.NEURON_NO(2), .NUM_WEIGHT(4), .LANES(1), .ACT_RELU(1)) u_c (
    .clk(clk), .rst(rst), .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value), .bias_valid(bias_valid),
    .bias_value(bias_value), .in_valid(in_valid && (sel == 2)), .in_ready(rdy[2]),
    .in_data(in_data[15:0]), .out(outs[2]), .out_valid(ov[2]), .sat_flag(sat[2]));

  neuron_mac_multilane #(.NEURON_NO(3), .NUM_WEIGHT(3), .LANES(2), .ACT_RELU(1)) u_d (
    .clk(clk), .rst(rst), .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value), .bias_valid(bias_valid),
    .bias_value(bias_value), .in_valid(in_valid && (sel == 3)), .in_ready(rdy[3]),
    .in_data(in_data), .out(outs[3]), .out_valid(ov[3]), .sat_flag(sat[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: Q1.15 products summed per beat, accumulator clamped to 32-bit signed,
  // output is acc/2^15 if acc fits in [-2^30, 2^30), else clamped.
  function automatic logic [15:0] model(input int s, output bit sat_o);
    longint acc, p, hi, lo;
    int     nb, l;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    acc = 0;
    sat_o = 1'b0;
    l = LANES_OF[s];
    nb = (NW_OF[s] + l - 1) / l;
    for (int b = 0; b < nb; b++) begin
      p = 0;
      for (int k = 0; k < l; k++)
        if (b * l + k < NW_OF[s])
          p += longint'($signed(wm[s][b*l+k])) * longint'($signed(xv[b*l+k]));
      acc += p;
      if (acc > hi) begin acc = hi; sat_o = 1'b1; end
      if (acc < lo) begin acc = lo; sat_o = 1'b1; end
    end
    acc += longint'($signed(bm[s])) * 32768;
    if (acc > hi) begin acc = hi; sat_o = 1'b1; end
    if (acc < lo) begin acc = lo; sat_o = 1'b1; end
    if (RELU_OF[s] != 0 && acc < 0) return 16'h0000;
    if (acc >= 64'sd1073741824)     return 16'h7FFF;
    if (acc < -64'sd1073741824)     return 16'h8000;
    return 16'(acc >>> 15);
  endfunction

  task automatic write_weight(input int neuron, input int layer, input logic [15:0] v);
    config_layer_num  = 32'(layer);
    config_neuron_num = 32'(neuron);
    weight_value      = {16'hA5A5, v};
    weight_valid      = 1'b1;
    @(negedge clk);
    weight_valid      = 1'b0;
  endtask

  task automatic write_bias(input int neuron, input logic [15:0] v);
    config_layer_num  = 32'd1;
    config_neuron_num = 32'(neuron);
    bias_value        = {16'h5A5A, v};
    bias_valid        = 1'b1;
    @(negedge clk);
    bias_valid        = 1'b0;
  endtask

  task automatic load(input int s, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      write_weight(s, 1, v);
      wm[s][i] = v;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_beat();
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!rdy[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input int s, input bit mid_bias);
    bit sm;
    int l, nb;
    sel = s;
    exp_q.push_back(model(s, sm));
    exp_sat = sm;
    l  = LANES_OF[s];
    nb = (NW_OF[s] + l - 1) / l;
    for (int b = 0; b < nb; b++) begin
      if (l == 2) in_data = {xv[2*b+1], xv[2*b]};
      else        in_data = {16'h0000, xv[b]};
      send_beat();
      if (mid_bias && b == 0) begin
        in_valid = 1'b0;
        write_bias(s, 16'h2000);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_x(input logic [15:0] v);
    for (int i = 0; i < 8; i++) xv[i] = v;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && rdy[sel]) last_acc <= cyc;
  end

  always @(negedge clk) begin
    if (!rst && ov[sel]) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out", 32'(outs[sel]), 32'(mon_e));
        chk("latency", 32'(cyc - last_acc), 32'd4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 0; in_valid = 1'b0; in_data = '0;
    weight_valid = 1'b0; bias_valid = 1'b0;
    config_layer_num = 32'd1; config_neuron_num = 32'd0;
    weight_value = '0; bias_value = '0;
    for (int s = 0; s < 4; s++) bm[s] = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_out",       32'(outs[0]), 32'h0);
    chk("rst_out_valid", 32'(ov[0]),   32'h0);
    chk("rst_in_ready",  32'(rdy[0]),  32'h0);
    chk("rst_sat",       32'(sat[2]),  32'h0);

    load(0, 16'h4000, 4);
    load(1, 16'hC000, 4);
    load(2, 16'h8000, 4);
    load(3, 16'h4000, 3);
    write_weight(3, 1, 16'h7FFF);

    // basic, bias, bias write ignored outside IDLE
    set_x(16'h2000); run(0, 1'b0); drain();
    write_bias(0, 16'h1000); bm[0] = 16'h1000;
    run(0, 1'b0); drain();
    run(0, 1'b1); drain();

    // output window saturation and ReLU, issued back to back
    write_bias(0, 16'h0000); bm[0] = 16'h0000;
    set_x(16'h4000); run(0, 1'b0);
    set_x(16'hC000); run(0, 1'b0); drain();
    chk("sat_a", 32'(sat[0]), 32'h0);

    // linear activation
    set_x(16'h4000); run(1, 1'b0); drain();
    set_x(16'h2000); run(1, 1'b0); drain();
    set_x(16'h7FFF); run(1, 1'b0); drain();

    // single lane, accumulator saturation
    set_x(16'h8000); run(2, 1'b0); drain();
`ifdef NEURON_SAT_FLAG_EN
    chk("sat_c_set", 32'(sat[2]), 32'(exp_sat));
`else
    chk("sat_c_off", 32'(sat[2]), 32'h0);
`endif
    set_x(16'h0000); run(2, 1'b0); drain();
    chk("sat_c_clr", 32'(sat[2]), 32'h0);

    // masked tail lane, no third beat
    set_x(16'h2000); xv[3] = 16'h7FFF; run(3, 1'b0);
    chk("tail_ready", 32'(rdy[3]), 32'h0);
    drain();

    // reset mid-accumulate, mismatched IDs, reload
    sel = 0; set_x(16'h2000);
    in_data = {xv[1], xv[0]};
    send_beat();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) bm[s] = 16'h0000;
    chk("rst_mid_valid", 32'(ov[0]),   32'h0);
    chk("rst_mid_ready", 32'(rdy[0]),  32'h0);
    chk("rst_mid_out",   32'(outs[0]), 32'h0);
    for (int i = 0; i < 4; i++) write_weight(7, 1, 16'h4000);
    write_weight(0, 2, 16'h4000);
    repeat (3) @(negedge clk);
    chk("id_mismatch_ready", 32'(rdy[0]), 32'h0);
    load(0, 16'h4000, 4);
    run(0, 1'b0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
